// File: rtl/elm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | elm_pkg : activation encodings, neuron FSM states, saturating shift   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package elm_pkg;

  localparam logic [1:0] ACT_IDENT = 2'd0;
  localparam logic [1:0] ACT_RELU  = 2'd1;
  localparam logic [1:0] ACT_HSIG  = 2'd2;

  typedef enum logic [2:0] {
    ST_ACC   = 3'd0,
    ST_DRAIN = 3'd1,
    ST_BIAS  = 3'd2,
    ST_ACT   = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

  localparam int SAT_W = 64;

  // Arithmetic (floor) right shift followed by clamp to a signed out_w range.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             shamt,
    input int unsigned             out_w
  );
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    s  = v >>> shamt;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    else             return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/elm_neuron_mac_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | elm_neuron_mac_if : config bus plus input/output streams of a neuron  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface elm_neuron_mac_if #(
  parameter int DATA_W = 16,
  parameter int CFG_W  = 8
);
  logic [CFG_W-1:0]  cfg_layer;
  logic [CFG_W-1:0]  cfg_neuron;
  logic              w_valid;
  logic [DATA_W-1:0] w_data;
  logic              b_valid;
  logic [DATA_W-1:0] b_data;
  logic [1:0]        act_sel;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              wr_err;

  modport master (
    output cfg_layer, cfg_neuron, w_valid, w_data, b_valid, b_data, act_sel,
           in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, wr_err
  );

  modport slave (
    input  cfg_layer, cfg_neuron, w_valid, w_data, b_valid, b_data, act_sel,
           in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, wr_err
  );
endinterface
`default_nettype wire

// File: rtl/neuron_weight_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | neuron_weight_ram : 1W/1R synchronous weight store, registered read   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module neuron_weight_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  // No reset: contents must survive rst.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule
`default_nettype wire

// File: rtl/elm_neuron_mac.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | elm_neuron_mac : streaming MAC neuron with bias, saturation, activation|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module elm_neuron_mac
  import elm_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 8,
  parameter int NUM_WEIGHT = 128,
  parameter int LAYER_NO   = 1,
  parameter int NEURON_NO  = 0,
  parameter int CFG_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  elm_neuron_mac_if.slave  bus
);
  localparam int CNT_W  = $clog2(NUM_WEIGHT);
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 2 * DATA_W + CNT_W;
  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(NUM_WEIGHT - 1);
  localparam logic signed [DATA_W:0]   HS_HALF  = (DATA_W+1)'(2 ** (FRAC_W - 1));
  localparam logic signed [DATA_W:0]   HS_ONE   = (DATA_W+1)'(2 ** FRAC_W);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, waddr_q;
  logic                      phase_q;
  logic                      v1_q, v2_q;
  logic signed [DATA_W-1:0]  in_q, bias_q, y_q, out_q;
  logic signed [DATA_W-1:0]  w_rdata;
  logic signed [PROD_W-1:0]  prod_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [1:0]                act_q;
  logic                      busy_q, wr_err_q;

  logic                      accept, out_fire, cfg_hit, w_we, b_we;
  logic signed [DATA_W:0]    hs;
  logic signed [DATA_W-1:0]  act_y;

  assign cfg_hit  = (bus.cfg_layer == CFG_W'(LAYER_NO)) && (bus.cfg_neuron == CFG_W'(NEURON_NO));
  assign w_we     = cfg_hit & bus.w_valid & ~busy_q;
  assign b_we     = cfg_hit & bus.b_valid & ~busy_q;
  assign accept   = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  neuron_weight_ram #(.DATA_W(DATA_W), .DEPTH(NUM_WEIGHT), .ADDR_W(CNT_W)) u_ram (
    .clk     (clk),
    .we_i    (w_we),
    .waddr_i (waddr_q),
    .wdata_i (bus.w_data),
    .re_i    (accept),
    .raddr_i (cnt_q),
    .rdata_o (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_ACC;
    else     state_q <= state_d;
  end

  // DRAIN and ACT each last two cycles; phase_q marks the second one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC:   if (accept && cnt_q == CNT_LAST) state_d = ST_DRAIN;
      ST_DRAIN: if (phase_q) state_d = ST_BIAS;
      ST_BIAS:  state_d = ST_ACT;
      ST_ACT:   if (phase_q) state_d = ST_OUT;
      ST_OUT:   if (bus.out_ready) state_d = ST_ACC;
      default:  state_d = ST_ACC;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == ST_ACC);
    bus.out_valid = (state_q == ST_OUT);
    bus.out_data  = out_q;
    bus.busy      = busy_q;
    bus.wr_err    = wr_err_q;
  end

  always_comb begin
    hs = (DATA_W+1)'(y_q >>> 2) + HS_HALF;
    case (act_q)
      ACT_RELU: act_y = y_q[DATA_W-1] ? '0 : y_q;
      ACT_HSIG: begin
        if (hs < 0)           act_y = '0;
        else if (hs > HS_ONE) act_y = HS_ONE[DATA_W-1:0];
        else                  act_y = hs[DATA_W-1:0];
      end
      default:  act_y = y_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (b_we) bias_q <= bus.b_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      waddr_q  <= '0;
      phase_q  <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      in_q     <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      y_q      <= '0;
      out_q    <= '0;
      act_q    <= ACT_IDENT;
      busy_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= cfg_hit & (bus.w_valid | bus.b_valid) & busy_q;
      if (w_we) waddr_q <= (waddr_q == CNT_LAST) ? '0 : waddr_q + CNT_W'(1);
      phase_q <= ((state_q == ST_DRAIN) || (state_q == ST_ACT)) & ~phase_q;
      v1_q    <= accept;
      v2_q    <= v1_q;
      if (accept) begin
        in_q   <= bus.in_data;
        cnt_q  <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        busy_q <= 1'b1;
        if (cnt_q == CNT_LAST) act_q <= bus.act_sel;
      end
      if (v1_q) prod_q <= in_q * w_rdata;
      case (state_q)
        ST_BIAS: acc_q <= acc_q + (ACC_W'(bias_q) <<< FRAC_W);
        ST_ACT: begin
          if (!phase_q) y_q   <= DATA_W'(sat_shift(SAT_W'(acc_q), FRAC_W, DATA_W));
          else          out_q <= act_y;
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
          end
        end
        default: if (v2_q) acc_q <= acc_q + ACC_W'(prod_q);
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_elm_neuron_mac.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_elm_neuron_mac : directed vector bench for elm_neuron_mac (N=4)    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_elm_neuron_mac;
  localparam int LAT = 5;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  elm_neuron_mac_if #(.DATA_W(16), .CFG_W(8)) bus ();

  elm_neuron_mac #(
    .DATA_W(16), .FRAC_W(8), .NUM_WEIGHT(4),
    .LAYER_NO(1), .NEURON_NO(0), .CFG_W(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [3:0][15:0] w;
    logic [15:0]     b;
    logic [3:0][15:0] x;
    logic [1:0]      act;
    logic [15:0]     exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0][15:0] w, input logic [15:0] b);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.cfg_layer  = 8'd1;
      bus.cfg_neuron = 8'd0;
      bus.w_valid    = 1'b1;
      bus.w_data     = w[i];
      bus.b_valid    = (i == 0);
      bus.b_data     = b;
    end
    @(negedge clk);
    bus.w_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask

  // Streams four inputs back-to-back, then checks latency, optional stall and recovery.
  task automatic run_vec(input logic [3:0][15:0] x, input logic [1:0] act, input int stall,
                         input bit inject, input string tag, output logic [15:0] res);
    int lat;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = x[i];
      bus.act_sel  = act;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.act_sel  = ~act;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      if (inject && lat == 1) begin
        bus.cfg_layer  = 8'd1;
        bus.cfg_neuron = 8'd0;
        bus.w_valid    = 1'b1;
        bus.w_data     = 16'h7FFF;
      end
      @(negedge clk);
      lat++;
      if (inject && lat == 2) begin
        bus.w_valid = 1'b0;
        chk({tag, " wr_err pulse"}, {31'd0, bus.wr_err}, 32'd1);
      end
      if (inject && lat == 3) chk({tag, " wr_err single"}, {31'd0, bus.wr_err}, 32'd0);
    end
    chk({tag, " latency"}, lat, LAT);
    res = bus.out_data;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, " stall data"}, {16'd0, bus.out_data}, {16'd0, res});
      chk({tag, " stall in_ready"}, {31'd0, bus.in_ready}, 32'd0);
      chk({tag, " stall busy"}, {31'd0, bus.busy}, 32'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, " post out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, " post in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    chk({tag, " post busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] res;
    logic        ov_seen;
    logic [3:0][15:0] w_one, x_basic;
    w_one   = {16'h0100, 16'h0100, 16'h0100, 16'h0100};
    x_basic = {16'h0400, 16'h0300, 16'h0200, 16'h0100};

    vecs[0] = '{"basic",    w_one, 16'h0080, x_basic, 2'd0, 16'h0A80};
    vecs[1] = '{"sat_pos",  {4{16'h7FFF}}, 16'h0000, {4{16'h7FFF}}, 2'd0, 16'h7FFF};
    vecs[2] = '{"relu_neg", {4{16'hFF00}}, 16'h0000, {4{16'h0100}}, 2'd1, 16'h0000};
    vecs[3] = '{"ident3",   {4{16'hFF00}}, 16'h0000, {4{16'h0100}}, 2'd3, 16'hFC00};
    vecs[4] = '{"hsig_0",   w_one, 16'h0000, {4{16'h0000}}, 2'd2, 16'h0080};
    vecs[5] = '{"hsig_4",   w_one, 16'h0000, {4{16'h0100}}, 2'd2, 16'h0100};
    vecs[6] = '{"hsig_m3",  {4{16'hFF00}}, 16'h0000, {16'h0000, 16'h0100, 16'h0100, 16'h0100}, 2'd2, 16'h0000};
    vecs[7] = '{"sat_neg",  {4{16'h8000}}, 16'h0000, {4{16'h7FFF}}, 2'd0, 16'h8000};
    vecs[8] = '{"relu_pos", w_one, 16'hFF80, {4{16'h0080}}, 2'd1, 16'h0180};
    vecs[9] = '{"floor",    {4{16'h0001}}, 16'h0000, {4{16'hFFFF}}, 2'd0, 16'hFFFF};

    bus.cfg_layer = '0; bus.cfg_neuron = '0;
    bus.w_valid = 0; bus.w_data = '0; bus.b_valid = 0; bus.b_data = '0;
    bus.act_sel = '0; bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready",  {31'd0, bus.in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset out_data",  {16'd0, bus.out_data}, 32'd0);
    chk("reset busy",      {31'd0, bus.busy}, 32'd0);
    chk("reset wr_err",    {31'd0, bus.wr_err}, 32'd0);

    for (int k = 0; k < 10; k++) begin
      cfg_write(vecs[k].w, vecs[k].b);
      run_vec(vecs[k].x, vecs[k].act, 0, 1'b0, vecs[k].name, res);
      chk({vecs[k].name, " result"}, {16'd0, res}, {16'd0, vecs[k].exp});
    end

    // Backpressure with the basic configuration.
    cfg_write(w_one, 16'h0080);
    run_vec(x_basic, 2'd0, 3, 1'b0, "bp", res);
    chk("bp result", {16'd0, res}, 32'h0A80);

    // Matched weight write while busy is dropped.
    run_vec(x_basic, 2'd0, 0, 1'b1, "busy_wr", res);
    chk("busy_wr result", {16'd0, res}, 32'h0A80);
    run_vec(x_basic, 2'd0, 0, 1'b0, "after_busy_wr", res);
    chk("after_busy_wr result", {16'd0, res}, 32'h0A80);

    // Mismatched neuron id is ignored silently.
    @(negedge clk);
    bus.cfg_neuron = 8'd5;
    bus.w_valid    = 1'b1;
    bus.w_data     = 16'h7FFF;
    @(negedge clk);
    bus.w_valid    = 1'b0;
    bus.cfg_neuron = 8'd0;
    chk("mismatch wr_err", {31'd0, bus.wr_err}, 32'd0);
    run_vec(x_basic, 2'd0, 0, 1'b0, "mismatch", res);
    chk("mismatch result", {16'd0, res}, 32'h0A80);

    // Reset after two accepted inputs.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0100;
    @(negedge clk);
    bus.in_data  = 16'h0200;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("midrst busy before", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy after", {31'd0, bus.busy}, 32'd0);
    ov_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ov_seen = ov_seen | bus.out_valid;
    end
    chk("midrst no out_valid", {31'd0, ov_seen}, 32'd0);
    run_vec(x_basic, 2'd0, 0, 1'b0, "midrst", res);
    chk("midrst result", {16'd0, res}, 32'h0A80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/elm_neuron_mac.md
# elm_neuron_mac

Parametrised streaming neuron for the ELM hidden/output layers. It accumulates NUM_WEIGHT input×weight products with a registered multiply pipeline, adds a Q-format bias and saturates to DATA_W. It then applies a runtime-selected activation (identity, ReLU, hard sigmoid) and presents the result on a valid/ready output. It is loaded through the shared layer/neuron configuration bus and instantiated once per neuron in a layer array.

## Interface
Parameters:
- DATA_W, 16, width of inputs, weights, bias, output (signed two's complement)
- FRAC_W, 8, fractional bits of all DATA_W quantities
- NUM_WEIGHT, 128, products per computation; ≥2
- LAYER_NO, 1, layer ID matched against cfg_layer
- NEURON_NO, 0, neuron ID matched against cfg_neuron
- CFG_W, 8, width of cfg_layer / cfg_neuron

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cfg_layer  in  CFG_W  target layer of current config write
- cfg_neuron  in  CFG_W  target neuron of current config write
- w_valid  in  1  weight write strobe
- w_data  in  DATA_W  weight value
- b_valid  in  1  bias write strobe
- b_data  in  DATA_W  bias value
- act_sel  in  2  0 identity, 1 ReLU, 2 hard sigmoid, 3 identity; sampled when the final product is accepted
- in_valid / in_ready  in / out  1  input handshake
- in_data  in  DATA_W  input activation
- out_valid / out_ready  out / in  1  output handshake
- out_data  out  DATA_W  activated result
- busy  out  1  high from first input accept until output handshake completes
- wr_err  out  1  one-cycle pulse: config write dropped

## Operation
- Config writes apply only when cfg_layer==LAYER_NO and cfg_neuron==NEURON_NO. Weight writes go to an auto-incrementing address starting at 0. The address wraps NUM_WEIGHT-1→0. b_valid loads the bias register.
- A matched config write while busy=1 is dropped and pulses wr_err. w_valid and b_valid in the same cycle are both applied.
- States: ACC, DRAIN, BIAS, ACT, OUT.
- ACC: in_ready=1. Each accept reads weight[cnt] and increments cnt. The accept at cnt==NUM_WEIGHT-1 goes to DRAIN and latches act_sel.
- DRAIN: 2 cycles, in_ready=0. The product pipeline empties into the accumulator.
- BIAS: acc + (sext(bias) << FRAC_W).
- ACT: y = sat_DATA_W(acc >>> FRAC_W), using arithmetic shift with floor truncation. Then:
  - ReLU: y<0 → 0.
  - Hard sigmoid: clamp((y >>> 2) + 2^(FRAC_W-1), 0, 2^FRAC_W).
- OUT: out_valid=1 and out_data is held stable until out_ready. On handshake, acc and cnt clear and the block returns to ACC; in_ready rises the next cycle.
- Accumulator width ACC_W = 2·DATA_W + clog2(NUM_WEIGHT). No internal overflow is possible; saturation happens only at ACT. Saturation limits are 2^(DATA_W-1)-1 and -2^(DATA_W-1).
- Stalls: in_valid low in ACC inserts bubbles with no state change. Partial sums are kept indefinitely.

## Timing
- Reset values:
  - Outputs: in_ready=1, out_valid=0, out_data=0, busy=0, wr_err=0.
  - Internal: state ACC, cnt=0, acc=0, weight write address=0.
  - Bias and weight RAM contents are retained through reset.
- Weight RAM: 1-cycle synchronous read. Product registered 1 cycle later; accumulated on the following edge.
- out_valid rises exactly 5 clock edges after the edge that accepts the last input, when out_ready had no prior stall.
- Zero-bubble throughput: NUM_WEIGHT+5 cycles per result, plus 1 recovery cycle after the output handshake.
- Reset mid-operation:
  - The partial sum is discarded; no out_valid follows.
  - Weights written before reset remain valid.
- A weight write is visible to a read that issues at least 1 cycle after the write edge.

## Structure
- Shared package `elm_pkg`:
  - ACT_IDENT / ACT_RELU / ACT_HSIG encodings
  - state enum
  - sat/shift helper function (also used by the layer array)
- Sub-module `neuron_weight_ram`: single-port-write, single-port-read synchronous RAM of NUM_WEIGHT×DATA_W.
- The FSM, MAC pipeline and activation stay in elm_neuron_mac.

## Test plan
All scenarios use DATA_W=16, FRAC_W=8, NUM_WEIGHT=4.
- Basic MAC:
  - Stimulus: weights 0x0100 ×4, bias 0x0080, inputs 0x0100, 0x0200, 0x0300, 0x0400 back-to-back, act=identity.
  - Response: out_data=0x0A80, out_valid 5 edges after the last accept.
- Saturation and ReLU:
  - Stimulus: weights and inputs all 0x7FFF, identity.
  - Response: out_data=0x7FFF.
  - Stimulus: weights all 0xFF00 (-1.0), inputs all 0x0100, ReLU.
  - Response: out_data=0x0000.
- Hard sigmoid:
  - Stimulus: sum 0.
  - Response: 0x0080.
  - Stimulus: sum 4.0.
  - Response: 0x0100.
  - Stimulus: sum -3.0.
  - Response: 0x0000.
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles.
  - Response: out_data stable, in_ready=0, busy=1. in_ready returns 1 cycle after the handshake.
- Config gating:
  - Stimulus: matched weight write while busy.
  - Response: wr_err pulse, result unchanged.
  - Stimulus: weight write with a mismatched cfg_neuron.
  - Response: ignored, no wr_err.
- Reset mid-accumulation:
  - Stimulus: rst after 2 inputs, then a full 4-input run with the same weights.
  - Response: no spurious out_valid, correct result 0x0A80.
